regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file with a pending-write scoreboard and a sequential clear engine. It replaces the single-write, two-read CPU register file. It serves a dual-issue datapath: NRD combinational read ports, two write ports, and per-entry busy tracking for the hazard unit. Entry 0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 44 ++++
 rtl/regfile_mp.sv | 120 ++++++++++++
 tb/tb_regfile_mp.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, port counts and clear-FSM state type for the multi-port register file.
package regfile_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NRD_DEF    = 2;
   localparam int NWR        = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pend bit per entry, set by reserve, released by write or clear.
// Callers gate the enables so that entry 0 is never set.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD    = NRD_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NWR-1:0]        rel_en,
   input  logic [NWR*ADDR_W-1:0] rel_addr,
   input  logic                  set_en,
   input  logic [ADDR_W-1:0]     set_addr,
   input  logic                  clr_en,
   input  logic [ADDR_W-1:0]     clr_addr,
   input  logic [NRD*ADDR_W-1:0] tap_addr,
   output logic [NRD-1:0]        tap
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] pend;

   // NOTE: sequential state uses non-blocking assignments; the last assignment in the
   // block wins, so the set is placed after the releases to give set-wins priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         for (int i = 0; i < NWR; i++) begin
            if (rel_en[i]) pend[rel_addr[i*ADDR_W +: ADDR_W]] <= 1'b0;
         end
         if (clr_en) pend[clr_addr] <= 1'b0;
         if (set_en) pend[set_addr] <= 1'b1;
      end
   end

   always_comb begin
      tap = '0;
      for (int k = 0; k < NRD; k++) begin
         tap[k] = pend[tap_addr[k*ADDR_W +: ADDR_W]];
      end
   end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two writes, pend scoreboard, sequential clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD    = NRD_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   output logic [NRD-1:0]        busy,
   input  logic [NWR-1:0]        we,
   input  logic [NWR*ADDR_W-1:0] waddr,
   input  logic [NWR*DATA_W-1:0] wdata,
   input  logic                  rsv_valid,
   input  logic [ADDR_W-1:0]     rsv_addr,
   input  logic                  clr_req,
   output logic                  clr_busy,
   output logic                  clr_done
);
   localparam int                DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

   clr_state_t        state, state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [NWR-1:0]    wr_ok;
   logic              rsv_ok;
   logic [NRD-1:0]    pend_tap;

   // Clear FSM: state register, counter and registered completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_done <= (state == ST_CLEAR) && (cnt == LAST);
         if (state == ST_CLEAR)   cnt <= cnt + 1'b1;
         else if (clr_req)        cnt <= ADDR_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (clr_req)       state_nxt = ST_CLEAR;
         ST_CLEAR: if (cnt == LAST)   state_nxt = ST_IDLE;
         default:                     state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      clr_busy = (state == ST_CLEAR);
   end

   // External writes and reserves are dropped while the clear engine owns the array
   always_comb begin
      wr_ok = '0;
      for (int i = 0; i < NWR; i++) begin
         wr_ok[i] = we[i] && (waddr[i*ADDR_W +: ADDR_W] != '0) && !clr_busy;
      end
      rsv_ok = rsv_valid && (rsv_addr != '0) && !clr_busy;
   end

   // NOTE: the array is reset because every entry must read 0 straight out of reset;
   // this maps it to flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
      end else if (clr_busy) begin
         mem[cnt] <= '0;
      end else begin
         for (int i = 0; i < NWR; i++) begin
            if (wr_ok[i]) mem[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   regfile_scoreboard #(
      .ADDR_W (ADDR_W),
      .NRD    (NRD)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .rel_en   (wr_ok),
      .rel_addr (waddr),
      .set_en   (rsv_ok),
      .set_addr (rsv_addr),
      .clr_en   (clr_busy),
      .clr_addr (cnt),
      .tap_addr (raddr),
      .tap      (pend_tap)
   );

   // NOTE: combinational logic uses blocking assignments with defaults first, so no latch forms.
   always_comb begin
      rdata = '0;
      busy  = '0;
      for (int k = 0; k < NRD; k++) begin
         if (!clr_busy) begin
            rdata[k*DATA_W +: DATA_W] = mem[raddr[k*ADDR_W +: ADDR_W]];
            busy[k]                   = pend_tap[k];
`ifdef REGFILE_BYPASS_EN
            // Ascending scan lets port 1 override port 0 on an address match
            for (int i = 0; i < NWR; i++) begin
               if (wr_ok[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr[k*ADDR_W +: ADDR_W])) begin
                  rdata[k*DATA_W +: DATA_W] = wdata[i*DATA_W +: DATA_W];
                  busy[k] = rsv_ok && (rsv_addr == raddr[k*ADDR_W +: ADDR_W]);
               end
            end
`endif
         end
      end
   end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios plus random traffic against an array model.
module tb_regfile_mp;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;
   localparam int DEPTH = 2**AW;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NRD*AW-1:0] raddr;
   logic [NRD*DW-1:0] rdata;
   logic [NRD-1:0]    busy;
   logic [1:0]        we;
   logic [2*AW-1:0]   waddr;
   logic [2*DW-1:0]   wdata;
   logic              rsv_valid;
   logic [AW-1:0]     rsv_addr;
   logic              clr_req;
   logic              clr_busy;
   logic              clr_done;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .raddr     (raddr),
      .rdata     (rdata),
      .busy      (busy),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .clr_req   (clr_req),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done)
   );

   typedef struct {
      string             tag;
      logic [NRD*DW-1:0] rdata;
      logic [NRD-1:0]    busy;
      logic              clr_busy;
      logic              clr_done;
   } exp_t;

   exp_t          exp_q[$];
   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] mem_m [DEPTH];
   bit            pend_m [DEPTH];
   int            clr_rem;
   bit            done_m;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: compare whatever the DUT presents against the oldest pending expectation
   exp_t e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({e.tag, " rdata"},    rdata,    e.rdata);
         check({e.tag, " busy"},     busy,     e.busy);
         check({e.tag, " clr_busy"}, clr_busy, e.clr_busy);
         check({e.tag, " clr_done"}, clr_done, e.clr_done);
      end
   end

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         mem_m[i]  = '0;
         pend_m[i] = 1'b0;
      end
      clr_rem = 0;
      done_m  = 1'b0;
   endfunction

   // Expected outputs for the inputs currently driven, before the next edge
   function automatic void predict(input string tag);
      exp_t          x;
      logic [AW-1:0] a;
      x.tag      = tag;
      x.rdata    = '0;
      x.busy     = '0;
      x.clr_busy = (clr_rem > 0);
      x.clr_done = done_m;
      for (int k = 0; k < NRD; k++) begin
         a = raddr[k*AW +: AW];
         if (clr_rem == 0) begin
            x.rdata[k*DW +: DW] = mem_m[a];
            x.busy[k]           = pend_m[a];
`ifdef REGFILE_BYPASS_EN
            if (a != 0 && ((we[0] && waddr[0 +: AW] == a) || (we[1] && waddr[AW +: AW] == a))) begin
               x.rdata[k*DW +: DW] = (we[1] && waddr[AW +: AW] == a) ? wdata[DW +: DW] : wdata[0 +: DW];
               x.busy[k] = rsv_valid && (rsv_addr == a);
            end
`endif
         end
      end
      exp_q.push_back(x);
   endfunction

   // State change at a clock edge; the clear is modelled as a countdown with a bulk wipe at the end
   function automatic void model_edge();
      if (clr_rem > 0) begin
         clr_rem--;
         done_m = (clr_rem == 0);
         if (clr_rem == 0) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_m[i]  = '0;
               pend_m[i] = 1'b0;
            end
         end
      end else begin
         done_m = 1'b0;
         for (int p = 0; p < 2; p++) begin
            if (we[p] && waddr[p*AW +: AW] != 0) begin
               mem_m[waddr[p*AW +: AW]]  = wdata[p*DW +: DW];
               pend_m[waddr[p*AW +: AW]] = 1'b0;
            end
         end
         if (rsv_valid && rsv_addr != 0) pend_m[rsv_addr] = 1'b1;
         if (clr_req) clr_rem = DEPTH - 1;
      end
   endfunction

   task automatic step(input string tag);
      predict(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      we        = '0;
      waddr     = '0;
      wdata     = '0;
      rsv_valid = 1'b0;
      rsv_addr  = '0;
      clr_req   = 1'b0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      raddr[0 +: AW]  = AW'(a0);
      raddr[AW +: AW] = AW'(a1);
   endtask

   task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
      we[p]              = 1'b1;
      waddr[p*AW +: AW]  = AW'(a);
      wdata[p*DW +: DW]  = d;
   endtask

   task automatic randomize_inputs(input bit allow_clr);
      we        = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
         waddr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         wdata[p*DW +: DW] = $urandom;
      end
      rsv_valid = 1'($urandom);
      rsv_addr  = AW'($urandom_range(0, 7));
      set_rd($urandom_range(0, 7), $urandom_range(0, DEPTH - 1));
      clr_req   = allow_clr && ($urandom_range(0, 63) == 0);
   endtask

   task automatic read_all(input string tag);
      idle();
      for (int i = 0; i < DEPTH; i += 2) begin
         set_rd(i, i + 1);
         step(tag);
      end
   endtask

   initial begin
      idle();
      set_rd(0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state on entries 0, 5, 31
      set_rd(0, 5);   step("rst_read_a");
      set_rd(31, 5);  step("rst_read_b");

      // Dual write to the same entry: port 1 wins; entry 0 ignores writes
      set_wr(0, 7, 32'h1111_1111);
      set_wr(1, 7, 32'h2222_2222);
      step("wr_collide");
      idle(); set_rd(7, 7); step("rd_7");
      set_wr(0, 0, 32'hDEAD_BEEF); step("wr_zero");
      idle(); set_rd(0, 0); step("rd_zero");

      // Reserve / release / set-wins on entry 9
      rsv_valid = 1'b1; rsv_addr = 5'd9; set_rd(9, 0); step("rsv_9");
      idle(); step("rd_9_busy");
      set_wr(0, 9, 32'h0000_00A5); step("wr_9");
      idle(); step("rd_9_free");
      set_wr(1, 9, 32'h0000_005A); rsv_valid = 1'b1; rsv_addr = 5'd9; step("rsv_wr_9");
      idle(); step("rd_9_setwins");

      // Full clear with traffic issued during the clear
      for (int i = 0; i < DEPTH; i += 2) begin
         set_wr(0, i, 32'hFFFF_FFFF);
         set_wr(1, i + 1, 32'hFFFF_FFFF);
         step("fill");
      end
      idle(); clr_req = 1'b1; set_rd(3, 31); step("clr_req");
      for (int c = 0; c < DEPTH - 1; c++) begin
         randomize_inputs(1'b0);
         step("clr_run");
      end
      idle(); step("clr_done");
      read_all("post_clr");

      // Reset in the middle of a clear
      for (int i = 1; i < DEPTH; i++) begin
         set_wr(0, i, $urandom);
         step("refill");
      end
      idle(); clr_req = 1'b1; step("clr_req2");
      idle();
      for (int c = 1; c < 10; c++) step("clr_run2");
      rst_n = 1'b0;
      #1;
      check("rst_mid rdata",    rdata,    '0);
      check("rst_mid busy",     busy,     '0);
      check("rst_mid clr_busy", clr_busy, '0);
      check("rst_mid clr_done", clr_done, '0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      read_all("post_rst");

      // Same-cycle write/read of entry 3 (bypass-dependent expectation)
      set_wr(0, 3, 32'h0000_AAAA); step("wr_3_old");
      idle(); set_wr(0, 3, 32'h0000_1234); set_rd(3, 3); step("wr_rd_3");
      idle(); step("rd_3_next");

      // Random traffic, occasional clears
      for (int n = 0; n < 400; n++) begin
         randomize_inputs(1'b1);
         step("rand");
      end
      idle();
      repeat (DEPTH + 2) step("drain");

      @(negedge clk);
      #1;
      check("queue_drained", 128'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
